imp_ln_stat_ctrl: RTL

Layer-norm statistics controller: accumulates a block of 2^N_LOG2 signed 8-bit samples and computes their mean and population variance. It then acts as the initiator of the square-root unit's start/done handshake to obtain the standard deviation. It sits upstream of the normalisation datapath, which consumes mean and std, and drives the 16-bit square-root unit.

---
 rtl/imp_ln_stat_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/imp_ln_stat_ctrl.sv
// rtl/imp_ln_stat_ctrl.sv - layer-norm mean/variance accumulator that requests the std from a sqrt unit
module imp_ln_stat_ctrl #(
  parameter int N_LOG2  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_sqrt_start,
  output logic [15:0] o_sqrt_data,
  input  logic        i_sqrt_done,
  input  logic [7:0]  i_sqrt_root,
  output logic        o_valid,
  output logic [7:0]  o_mean,
  output logic [15:0] o_var,
  output logic [7:0]  o_std,
  output logic        o_err
);

  localparam int SW = 8 + N_LOG2;
  localparam int QW = 15 + N_LOG2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_ACC, S_CALC, S_REQ, S_WAIT, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [QW-1:0]     sumsq_q, sumsq_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        mean_q, mean_d;
  logic [15:0]       var_q, var_d;
  logic [15:0]       rad_q, rad_d;
  logic [7:0]        omean_q, omean_d;
  logic [15:0]       ovar_q, ovar_d;
  logic [7:0]        std_q, std_d;
  logic              err_q, err_d;

  logic [7:0]        mag;
  logic [15:0]       sq;
  logic [7:0]        mean_c;
  logic [14:0]       ex2_c;
  logic signed [15:0] mean_sq;
  logic signed [16:0] var17;
  logic [15:0]       var_c;
  logic              tmo_hit;

  // Dropping the low N_LOG2 bits of a two's-complement sum is a floor division.
  always_comb begin
    mag     = i_data[7] ? (8'd0 - i_data) : i_data;
    sq      = mag * mag;
    mean_c  = sum_q[SW-1 -: 8];
    ex2_c   = sumsq_q[QW-1 -: 15];
    mean_sq = $signed(mean_c) * $signed(mean_c);
    var17   = $signed({2'b00, ex2_c}) - $signed({1'b0, mean_sq});
    var_c   = var17[16] ? 16'd0 : var17[15:0];
    tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (i_valid && (&cnt_q)) state_d = S_CALC;
      S_CALC:  state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (i_sqrt_done || tmo_hit) state_d = S_OUT;
      S_OUT:   state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    mean_d  = mean_q;
    var_d   = var_q;
    rad_d   = rad_q;
    omean_d = omean_q;
    ovar_d  = ovar_q;
    std_d   = std_q;
    err_d   = err_q;
    case (state_q)
      S_ACC: begin
        if (i_valid) begin
          sum_d   = sum_q + {{N_LOG2{i_data[7]}}, i_data};
          sumsq_d = sumsq_q + QW'(sq);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_CALC: begin
        mean_d = mean_c;
        var_d  = var_c;
        rad_d  = var_c;
      end
      S_REQ: tmo_d = '0;
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // Done wins over a timeout landing in the same cycle.
        if (i_sqrt_done || tmo_hit) begin
          std_d   = i_sqrt_done ? i_sqrt_root : 8'd0;
          err_d   = !i_sqrt_done;
          omean_d = mean_q;
          ovar_d  = var_q;
        end
      end
      S_OUT: begin
        sum_d   = '0;
        sumsq_d = '0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q   <= '0;
      sumsq_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      mean_q  <= '0;
      var_q   <= '0;
      rad_q   <= '0;
      omean_q <= '0;
      ovar_q  <= '0;
      std_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      mean_q  <= mean_d;
      var_q   <= var_d;
      rad_q   <= rad_d;
      omean_q <= omean_d;
      ovar_q  <= ovar_d;
      std_q   <= std_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    o_ready      = (state_q == S_ACC);
    o_sqrt_start = (state_q == S_REQ);
    o_valid      = (state_q == S_OUT);
    o_sqrt_data  = rad_q;
    o_mean       = omean_q;
    o_var        = ovar_q;
    o_std        = std_q;
    o_err        = err_q;
  end

endmodule
